// File: rtl/uart_pkg.sv
// Shared UART definitions used by the receiver, the transmitter and the baud
// tick divider.
//   uart_state_t   : frame state encoding common to uart_rx and uart_tx
//   DATA_BITS      : payload bits per frame (8N1)
//   calc_tick_div  : clocks per oversampling tick, integer-truncated
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_t;

   localparam int DATA_BITS = 8;

   function automatic int calc_tick_div(input int clk_freq, input int baud_rate,
                                        input int oversample);
      return clk_freq / (baud_rate * oversample);
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side output bundle of uart_rx.
//   rx_data   : last correctly received byte
//   rx_valid  : one-clk strobe, rx_data is new this cycle
//   frame_err : one-clk strobe, stop bit sampled low and byte dropped
//   rx_busy   : a frame is in progress
// master = receiver (drives), slave = consumer (observes).
interface uart_rx_if;
   import uart_pkg::*;

   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_valid;
   logic                 frame_err;
   logic                 rx_busy;

   modport master (output rx_data, rx_valid, frame_err, rx_busy);
   modport slave  (input  rx_data, rx_valid, frame_err, rx_busy);

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick divider. Counts 0..TICK_DIV-1 and pulses tick for one clk
// on the wrap. A synchronous clear holds the counter at zero so the tick phase
// can be re-aligned to an external event (the start edge on the receiver).
//   clk, reset : system clock, asynchronous active-high reset
//   clear      : hold counter at zero, suppress tick
//   tick       : one-clk pulse every TICK_DIV clks while clear is low
module uart_baud_tick #(
   parameter int TICK_DIV = 162
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

   logic [CNT_W-1:0] tick_cnt;
   logic             at_top;

   assign at_top = (tick_cnt == CNT_W'(TICK_DIV - 1));
   assign tick   = at_top && !clear;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         tick_cnt <= '0;
      else if (clear || at_top)
         tick_cnt <= '0;
      else
         tick_cnt <= tick_cnt + 1'b1;
   end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver. rx is synchronised by two flops (rx_s); a falling edge of
// rx_s in IDLE starts a frame and phase-aligns the oversampling tick. Each bit
// is decided by a 3-sample majority vote around the bit centre, LSB first.
// The stop bit is decided mid-bit and the FSM returns to IDLE immediately, so
// back-to-back frames and moderate baud mismatch are tolerated.
//   clk, reset : system clock, asynchronous active-high reset
//   rx         : raw line, idles high, asynchronous to clk
//   rx_bus     : rx_data / rx_valid / frame_err / rx_busy (uart_rx_if.master)
module uart_rx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 25000000,
   parameter int BAUD_RATE  = 9600,
   parameter int OVERSAMPLE = 16,
   parameter int TICK_DIV   = calc_tick_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE)
) (
   input  logic      clk,
   input  logic      reset,
   input  logic      rx,
   uart_rx_if.master rx_bus
);

   localparam int SAMP_W = $clog2(OVERSAMPLE);
   localparam int IDX_W  = $clog2(DATA_BITS);
   localparam int MID    = OVERSAMPLE / 2;

   uart_state_t state, next_state;

   logic                 rx_p0, rx_s, rx_prev;
   logic                 start_edge;
   logic                 tick;
   logic [SAMP_W-1:0]    samp_cnt, samp_nxt;
   logic                 vote_a_tick, vote_b_tick, decide_tick, bit_end;
   logic                 samp_a, samp_b, majority;
   logic [IDX_W-1:0]     bit_idx;
   logic [DATA_BITS-1:0] shreg;
   logic [DATA_BITS-1:0] rx_data_r;
   logic                 rx_valid_r, frame_err_r;
   logic                 valid_nxt, err_nxt;

   // Synchroniser stage: rx -> rx_p0 -> rx_s, plus edge history
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_p0   <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_p0   <= rx;
         rx_s    <= rx_p0;
         rx_prev <= rx_s;
      end
   end

   assign start_edge = rx_prev && !rx_s;

   uart_baud_tick #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk   (clk),
      .reset (reset),
      .clear (state == IDLE),
      .tick  (tick)
   );

   // samp_nxt is the tick count within the bit including the current tick, so
   // the votes straddle the true bit centre and the wrap marks the bit end.
   assign samp_nxt    = samp_cnt + 1'b1;
   assign vote_a_tick = tick && (samp_nxt == SAMP_W'(MID - 1));
   assign vote_b_tick = tick && (samp_nxt == SAMP_W'(MID));
   assign decide_tick = tick && (samp_nxt == SAMP_W'(MID + 1));
   assign bit_end     = tick && (samp_nxt == '0);
   assign majority    = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      valid_nxt  = 1'b0;
      err_nxt    = 1'b0;
      case (state)
         IDLE:  if (start_edge) next_state = START;
         START: begin
            if (decide_tick && majority) next_state = IDLE;   // false start
            else if (bit_end)            next_state = DATA;
         end
         DATA:  if (bit_end && bit_idx == IDX_W'(DATA_BITS - 1)) next_state = STOP;
         STOP: begin
            if (decide_tick) begin
               next_state = IDLE;
               valid_nxt  = majority;
               err_nxt    = !majority;
            end
         end
         default: next_state = IDLE;
      endcase
   end

   // Sampling / shift stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         samp_cnt <= '0;
         bit_idx  <= '0;
         samp_a   <= 1'b1;
         samp_b   <= 1'b1;
         shreg    <= '0;
      end else begin
         if (state == IDLE) begin
            samp_cnt <= '0;
            bit_idx  <= '0;
         end else if (tick) begin
            samp_cnt <= samp_nxt;
         end
         if (vote_a_tick) samp_a <= rx_s;
         if (vote_b_tick) samp_b <= rx_s;
         if (state == DATA) begin
            if (decide_tick) shreg[bit_idx] <= majority;
            if (bit_end && bit_idx != IDX_W'(DATA_BITS - 1)) bit_idx <= bit_idx + 1'b1;
         end
      end
   end

   // Output stage
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rx_data_r   <= '0;
         rx_valid_r  <= 1'b0;
         frame_err_r <= 1'b0;
      end else begin
         rx_valid_r  <= valid_nxt;
         frame_err_r <= err_nxt;
         if (valid_nxt) rx_data_r <= shreg;
      end
   end

   assign rx_bus.rx_data   = rx_data_r;
   assign rx_bus.rx_valid  = rx_valid_r;
   assign rx_bus.frame_err = frame_err_r;
   assign rx_bus.rx_busy   = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 160 clks per bit (TICK_DIV = 10).
module tb_uart_rx;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic rx = 1'b1;

   uart_rx_if bus ();

   uart_rx #(
      .CLK_FREQ   (1600000),
      .BAUD_RATE  (10000),
      .OVERSAMPLE (16)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .rx     (rx),
      .rx_bus (bus.master)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Pulse monitor, sampled on the inactive edge
   int         valid_cnt = 0;
   int         err_cnt = 0;
   int         busy_bad = 0;
   int         excl_bad = 0;
   logic       prev_busy = 1'b0;
   logic [7:0] got[$];

   always @(negedge clk) begin
      if (bus.rx_valid) begin
         valid_cnt++;
         got.push_back(bus.rx_data);
         // busy must drop the same cycle valid rises
         if (bus.rx_busy || !prev_busy) busy_bad++;
      end
      if (bus.frame_err) err_cnt++;
      if (bus.rx_valid && bus.frame_err) excl_bad++;
      prev_busy = bus.rx_busy;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] b, input int bit_clks, input logic stop_bit);
      rx = 1'b0;
      idle(bit_clks);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         idle(bit_clks);
      end
      rx = stop_bit;
      idle(bit_clks);
      rx = 1'b1;
   endtask

   int v0, e0, n0;

   initial begin
      idle(3);
      chk("reset_rx_data",   32'(bus.rx_data),   32'h0);
      chk("reset_rx_valid",  32'(bus.rx_valid),  32'h0);
      chk("reset_frame_err", 32'(bus.frame_err), 32'h0);
      chk("reset_rx_busy",   32'(bus.rx_busy),   32'h0);
      reset = 1'b0;
      idle(20);

      // Single frame 0x55
      v0 = valid_cnt; e0 = err_cnt; n0 = got.size();
      send_frame(8'h55, 160, 1'b1);
      idle(50);
      chk("single_valid_cnt", 32'(valid_cnt - v0), 32'd1);
      chk("single_data",      32'(got[n0]),        32'h55);
      chk("single_rx_data",   32'(bus.rx_data),    32'h55);
      chk("single_no_ferr",   32'(err_cnt - e0),   32'd0);

      // Back-to-back 0xA5, 0x3C
      v0 = valid_cnt; e0 = err_cnt; n0 = got.size();
      send_frame(8'hA5, 160, 1'b1);
      send_frame(8'h3C, 160, 1'b1);
      idle(50);
      chk("b2b_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      chk("b2b_first",     32'(got[n0]),        32'hA5);
      chk("b2b_second",    32'(got[n0 + 1]),    32'h3C);
      chk("b2b_no_ferr",   32'(err_cnt - e0),   32'd0);

      // 40-clk low glitch: false start
      v0 = valid_cnt; e0 = err_cnt;
      rx = 1'b0;
      idle(20);
      chk("glitch_busy_up", 32'(bus.rx_busy), 32'd1);
      idle(20);
      rx = 1'b1;
      idle(100);
      chk("glitch_busy_down", 32'(bus.rx_busy),   32'd0);
      chk("glitch_no_valid",  32'(valid_cnt - v0), 32'd0);
      chk("glitch_no_ferr",   32'(err_cnt - e0),   32'd0);
      idle(200);

      // Good 0x55 then 0xFF with stop bit low
      v0 = valid_cnt;
      send_frame(8'h55, 160, 1'b1);
      idle(50);
      chk("pre_ferr_valid", 32'(valid_cnt - v0), 32'd1);
      v0 = valid_cnt; e0 = err_cnt;
      send_frame(8'hFF, 160, 1'b0);
      idle(50);
      chk("ferr_pulse",    32'(err_cnt - e0),   32'd1);
      chk("ferr_no_valid", 32'(valid_cnt - v0), 32'd0);
      chk("ferr_rx_data",  32'(bus.rx_data),    32'h55);
      idle(200);

      // Baud tolerance: 0xC3 fast then slow
      v0 = valid_cnt; e0 = err_cnt; n0 = got.size();
      send_frame(8'hC3, 150, 1'b1);
      idle(200);
      send_frame(8'hC3, 170, 1'b1);
      idle(200);
      chk("baud_valid_cnt", 32'(valid_cnt - v0), 32'd2);
      chk("baud_fast_data", 32'(got[n0]),        32'hC3);
      chk("baud_slow_data", 32'(got[n0 + 1]),    32'hC3);
      chk("baud_no_ferr",   32'(err_cnt - e0),   32'd0);

      // Reset during data bit 4 of 0x96 (bits 0..3 = 0,1,1,0; bit 4 = 1)
      v0 = valid_cnt; e0 = err_cnt;
      rx = 1'b0; idle(160);
      rx = 1'b0; idle(160);
      rx = 1'b1; idle(160);
      rx = 1'b1; idle(160);
      rx = 1'b0; idle(160);
      rx = 1'b1; idle(80);
      chk("midframe_busy", 32'(bus.rx_busy), 32'd1);
      reset = 1'b1;
      #1;
      chk("rst_rx_data",   32'(bus.rx_data),   32'h0);
      chk("rst_rx_valid",  32'(bus.rx_valid),  32'h0);
      chk("rst_frame_err", 32'(bus.frame_err), 32'h0);
      chk("rst_rx_busy",   32'(bus.rx_busy),   32'h0);
      rx = 1'b1;
      idle(5);
      reset = 1'b0;
      idle(300);
      chk("rst_no_valid", 32'(valid_cnt - v0), 32'd0);
      chk("rst_no_ferr",  32'(err_cnt - e0),   32'd0);
      v0 = valid_cnt; n0 = got.size();
      send_frame(8'h5A, 160, 1'b1);
      idle(50);
      chk("post_rst_valid", 32'(valid_cnt - v0), 32'd1);
      chk("post_rst_data",  32'(got[n0]),        32'h5A);

      chk("busy_vs_valid_timing", 32'(busy_bad), 32'd0);
      chk("valid_ferr_exclusive", 32'(excl_bad), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
